// File: rtl/inst_loader.sv
// Program loader and instruction store: assembles a framed byte stream into
// 32-bit words, verifies an XOR checksum and serves the processor fetch port.
module inst_loader #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   input  logic          start,
   input  logic [7:0]    in_byte,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          fetch_en,
   input  logic [AW-1:0] fetch_addr,
   output logic [31:0]   fetch_data,
   output logic          cpu_hold,
   output logic          prog_valid,
   output logic          load_done,
   output logic          err_len,
   output logic          err_csum,
   output logic [AW:0]   word_count
);

   localparam logic [31:0] HALT_INSN = 32'hD800_0000;
   localparam logic [7:0]  DEPTH_B   = 8'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_reg;
   logic [AW:0]   n_reg;
   logic [AW:0]   word_count_reg;
   logic [1:0]    byte_idx_reg;
   logic [23:0]   word_asm_reg;
   logic [7:0]    csum_reg;
   logic          in_ready_reg;
   logic          cpu_hold_reg;
   logic          prog_valid_reg;
   logic          load_done_reg;
   logic          err_len_reg;
   logic          err_csum_reg;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   mem_rd_reg;
   logic          fetch_hit_reg;

   logic          accept;
   logic          len_bad;
   logic          wr_en;
   logic [31:0]   word_next;
   logic [AW:0]   count_inc;

   assign accept    = in_valid & in_ready_reg;
   assign len_bad   = (in_byte == 8'd0) || (in_byte > DEPTH_B);
   assign word_next = {word_asm_reg, in_byte};
   assign count_inc = word_count_reg + 1'b1;
   assign wr_en     = accept && (state_reg == S_DATA) && (byte_idx_reg == 2'd3);

   // Load sequencer; all status outputs are registered here.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state_reg      <= S_IDLE;
         n_reg          <= '0;
         word_count_reg <= '0;
         byte_idx_reg   <= '0;
         word_asm_reg   <= '0;
         csum_reg       <= '0;
         in_ready_reg   <= 1'b0;
         cpu_hold_reg   <= 1'b1;
         prog_valid_reg <= 1'b0;
         load_done_reg  <= 1'b0;
         err_len_reg    <= 1'b0;
         err_csum_reg   <= 1'b0;
      end else begin
         load_done_reg <= 1'b0;
         case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_reg      <= S_LEN;
                  in_ready_reg   <= 1'b1;
                  cpu_hold_reg   <= 1'b1;
                  prog_valid_reg <= 1'b0;
                  err_len_reg    <= 1'b0;
                  err_csum_reg   <= 1'b0;
                  word_count_reg <= '0;
                  byte_idx_reg   <= '0;
                  csum_reg       <= '0;
               end
            end
            S_LEN: begin
               if (accept) begin
                  if (len_bad) begin
                     state_reg    <= S_ERR;
                     err_len_reg  <= 1'b1;
                     in_ready_reg <= 1'b0;
                  end else begin
                     n_reg     <= in_byte[AW:0];
                     state_reg <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  word_asm_reg <= word_next[23:0];
                  csum_reg     <= csum_reg ^ in_byte;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     word_count_reg <= count_inc;
                     if (count_inc == n_reg) begin
                        state_reg <= S_CSUM;
                     end
                  end
               end
            end
            S_CSUM: begin
               if (accept) begin
                  in_ready_reg <= 1'b0;
                  if (in_byte == csum_reg) begin
                     state_reg      <= S_DONE;
                     prog_valid_reg <= 1'b1;
                     load_done_reg  <= 1'b1;
                     cpu_hold_reg   <= 1'b0;
                  end else begin
                     state_reg    <= S_ERR;
                     err_csum_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg    <= S_IDLE;
               in_ready_reg <= 1'b0;
               cpu_hold_reg <= 1'b1;
            end
         endcase
      end
   end

   // Instruction RAM: contents survive reset; a same-address read sees old data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[word_count_reg[AW-1:0]] <= word_next;
      end
      if (fetch_en) begin
         mem_rd_reg <= mem[fetch_addr];
      end
   end

   // Hit flag decides at fetch time whether the RAM word or halt is returned.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         fetch_hit_reg <= 1'b0;
      end else if (fetch_en) begin
         fetch_hit_reg <= prog_valid_reg && ({1'b0, fetch_addr} < word_count_reg);
      end
   end

   assign fetch_data = fetch_hit_reg ? mem_rd_reg : HALT_INSN;
   assign in_ready   = in_ready_reg;
   assign cpu_hold   = cpu_hold_reg;
   assign prog_valid = prog_valid_reg;
   assign load_done  = load_done_reg;
   assign err_len    = err_len_reg;
   assign err_csum   = err_csum_reg;
   assign word_count = word_count_reg;

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader and instruction store for the 32-bit processor: receives a framed byte stream on a valid/ready input, assembles 32-bit instruction words MSB-first, writes them into a 16-entry instruction memory, and checks an XOR checksum. It also serves the processor's fetch port. It holds the processor off (`cpu_hold`) while a load is in progress. Fetches beyond the loaded program return a `halt` instruction, so an incompletely loaded program stops cleanly.

## Interface
- `DEPTH`, 16, instruction memory entries (power of two)
- `AW`, 4, address width, log2(DEPTH)
- `clk`  in  1  single clock, all logic on rising edge
- `sys_rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a new load (sampled in IDLE, DONE, ERR)
- `in_byte`  in  8  stream data
- `in_valid`  in  1  stream byte valid
- `in_ready`  out  1  loader accepts byte this cycle
- `fetch_en`  in  1  fetch request
- `fetch_addr`  in  AW  fetch word address (processor PC)
- `fetch_data`  out  32  fetched instruction, registered
- `cpu_hold`  out  1  processor must stay in idle/reset
- `prog_valid`  out  1  a complete, checksum-correct program is resident
- `load_done`  out  1  one-cycle pulse on successful load
- `err_len`  out  1  sticky: bad length byte
- `err_csum`  out  1  sticky: checksum mismatch
- `word_count`  out  AW+1  words written in the current or last load

## Operation
- Accept = `in_valid & in_ready`. `in_ready` = 1 only in LEN, DATA, CSUM.
- Frame: byte 0 = N (word count), then 4N data bytes (MSB of each word first), then 1 checksum byte = XOR of all 4N data bytes. The length byte is not included in the checksum.
- States:
  - IDLE: `start` -> LEN. On entry to LEN: clear `prog_valid`, `err_len`, `err_csum`, `word_count`, the byte index and the XOR accumulator; assert `cpu_hold`.
  - LEN: on accept, N=0 or N>DEPTH -> ERR with `err_len`=1. Otherwise latch N -> DATA.
  - DATA: on accept, shift the byte into a 32-bit assembly register and XOR it into the accumulator. On the 4th byte of a word:
    - write the word to mem[`word_count`];
    - increment `word_count`;
    - if the new count equals N -> CSUM.
  - CSUM: on accept, byte equal to accumulator -> DONE (`prog_valid`=1, `load_done` pulse). Otherwise -> ERR (`err_csum`=1).
  - DONE / ERR: `cpu_hold`=0 in DONE and 1 in ERR. `start` -> LEN, reinitialised as above.
- `start` in LEN/DATA/CSUM is ignored.
- Fetch: when `fetch_en`=1, `fetch_data` on the next cycle is:
  - mem[`fetch_addr`] if `prog_valid`=1 and `fetch_addr` < `word_count`;
  - otherwise 32'hD800_0000 (opcode 11011 `halt`, all other fields 0).
- When `fetch_en`=0, `fetch_data` holds its value.
- Simultaneous write and fetch of the same address: the fetch returns the pre-write contents.
- Memory contents are not cleared by reset or by `start`. Stale words are masked by `prog_valid` and `word_count`.

## Timing
- Reset (`sys_rst_n`=0 at an edge) values:
  - state IDLE;
  - `in_ready`=0, `cpu_hold`=1, `prog_valid`=0, `load_done`=0;
  - `err_len`=0, `err_csum`=0, `word_count`=0;
  - `fetch_data`=32'hD800_0000.
- Reset mid-load aborts the load. No partial program is ever valid.
- One byte can be accepted per cycle. Back-to-back bytes are accepted at full rate with no bubbles, including across word boundaries and the DATA->CSUM transition.
- Memory write occurs on the same edge that accepts the 4th byte of a word.
- `prog_valid` and the `load_done` pulse go high on the edge after the checksum accept. `cpu_hold` falls on that same edge.
- `in_ready` goes low on the edge that accepts the final (checksum or bad-length) byte.
- Fetch latency is exactly 1 cycle.
- `in_valid` low inside a word stalls the load without losing the partially assembled word.
- `word_count` saturates at N; N=DEPTH is legal and fills every entry, with no wrap.

## Test plan
- Load N=2, words 0x0800_0005 and 0x1000_0003, checksum 0x08^0x05^0x10^0x03=0x1E:
  - `load_done` pulses once, `prog_valid`=1, `word_count`=2, `cpu_hold` falls;
  - fetch addr 0/1 returns the words one cycle later;
  - fetch addr 2 returns 0xD800_0000.
- Same frame with checksum 0x1F -> `err_csum`=1, `prog_valid`=0, `cpu_hold`=1, every fetch returns 0xD800_0000. Then `start` clears `err_csum` and a correct reload succeeds.
- Length byte 0x00, then separately 0x11 -> `err_len`=1, `in_ready`=0 on the next cycle, no memory writes.
- N=16 with random `in_valid` gaps -> all 16 words read back exactly, `word_count`=16, no wrap.
- Assert `sys_rst_n`=0 after 6 data bytes of an N=3 load -> all outputs at reset values, fetch of addr 0 returns 0xD800_0000.
- `start` pulsed mid-DATA -> ignored, and the load completes normally.
